// File: rtl/ts_queue_wr_arb_if.sv
// Write port of the timestamp queue, as seen between the arbiter (master) and the FIFO (slave).
// Handshake: q_wrreq is a one-cycle write pulse, and the write is taken in that same cycle.
// The master raises it only while q_wrfull=0 and q_wrusedw is below its almost-full level.
interface ts_queue_wr_arb_if #(
  parameter int TS_W = 80,
  parameter int UW   = 4
);
  logic            q_wrreq;
  logic [TS_W-1:0] q_data;
  logic            q_wrfull;
  logic [UW-1:0]   q_wrusedw;

  modport master (output q_wrreq, q_data, input q_wrfull, q_wrusedw);
  modport slave  (input q_wrreq, q_data, output q_wrfull, q_wrusedw);
endinterface

// File: rtl/ts_queue_wr_arb.sv
// Round-robin arbiter sharing one timestamp FIFO write port between N_SRC non-stallable sources.
// Optional per-source saturating drop counters are built when TS_QUEUE_DROP_CNT_EN is defined.
module ts_queue_wr_arb #(
  parameter int N_SRC     = 2,
  parameter int TS_W      = 80,
  parameter int UW        = 4,
  parameter int AFULL_LVL = 14
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_SRC-1:0]      src_stb,
  input  logic [N_SRC*TS_W-1:0] src_ts,
  ts_queue_wr_arb_if.master     q,
  output logic [N_SRC-1:0]      pend,
  output logic [N_SRC-1:0]      drop_flag,
  input  logic                  cnt_clr,
  output logic [N_SRC*16-1:0]   drop_cnt
);

  localparam int PW = (N_SRC > 1) ? $clog2(N_SRC) : 1;

  logic [PW-1:0]   rr_ptr;
  logic [PW-1:0]   gnt_idx;
  logic [PW:0]     sum;
  logic            gnt_vld;
  logic            grant;
  logic [N_SRC-1:0] gnt_oh;
  logic [N_SRC-1:0] drop;
  logic [TS_W-1:0] holder [N_SRC];

  // Scan downward so the lowest offset from rr_ptr is the one that survives.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    sum     = '0;
    for (int k = N_SRC - 1; k >= 0; k--) begin
      sum = {1'b0, rr_ptr} + (PW+1)'(k);
      if (sum >= (PW+1)'(N_SRC)) sum = sum - (PW+1)'(N_SRC);
      if (pend[sum[PW-1:0]]) begin
        gnt_vld = 1'b1;
        gnt_idx = sum[PW-1:0];
      end
    end
  end

  // The q_wrreq term spaces writes two cycles apart, covering the FIFO flag latency.
  assign grant = gnt_vld && !q.q_wrfull && (int'(q.q_wrusedw) < AFULL_LVL) && !q.q_wrreq;

  always_comb begin
    gnt_oh = '0;
    drop   = '0;
    for (int i = 0; i < N_SRC; i++) begin
      gnt_oh[i] = grant && (gnt_idx == PW'(i));
      drop[i]   = src_stb[i] && pend[i] && !gnt_oh[i];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q.q_wrreq <= 1'b0;
      q.q_data  <= '0;
      pend      <= '0;
      drop_flag <= '0;
      rr_ptr    <= '0;
      for (int i = 0; i < N_SRC; i++) holder[i] <= '0;
    end else begin
      q.q_wrreq <= grant;
      if (grant) begin
        q.q_data <= holder[gnt_idx];
        rr_ptr   <= (gnt_idx == PW'(N_SRC - 1)) ? '0 : gnt_idx + PW'(1);
      end
      for (int i = 0; i < N_SRC; i++) begin
        // A strobe on the granting edge reloads the holder rather than dropping.
        if (src_stb[i] && (!pend[i] || gnt_oh[i])) begin
          holder[i] <= src_ts[i*TS_W +: TS_W];
          pend[i]   <= 1'b1;
        end else if (gnt_oh[i]) begin
          pend[i] <= 1'b0;
        end
        if (cnt_clr)      drop_flag[i] <= 1'b0;
        else if (drop[i]) drop_flag[i] <= 1'b1;
      end
    end
  end

`ifdef TS_QUEUE_DROP_CNT_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt <= '0;
    end else begin
      for (int i = 0; i < N_SRC; i++) begin
        if (cnt_clr)
          drop_cnt[i*16 +: 16] <= 16'h0000;
        else if (drop[i] && (drop_cnt[i*16 +: 16] != 16'hFFFF))
          drop_cnt[i*16 +: 16] <= drop_cnt[i*16 +: 16] + 16'd1;
      end
    end
  end
`else
  assign drop_cnt = '0;
`endif

endmodule
